// File: rtl/control_pkg.sv
// Shared encodings for the decode-stage control unit and its E/M/W pipeline.
package control_pkg;

  // Base and extended opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // ALU code set A (3-bit, base operations)
  localparam logic [2:0] ALU_A_ADD = 3'b000;
  localparam logic [2:0] ALU_A_SUB = 3'b001;
  localparam logic [2:0] ALU_A_AND = 3'b010;
  localparam logic [2:0] ALU_A_OR  = 3'b011;
  localparam logic [2:0] ALU_A_SLT = 3'b101;

  // ALU code set B (4-bit); the shared operations are the zero-extended set A codes
  localparam logic [3:0] ALU_B_ADD  = 4'b0000;
  localparam logic [3:0] ALU_B_SUB  = 4'b0001;
  localparam logic [3:0] ALU_B_AND  = 4'b0010;
  localparam logic [3:0] ALU_B_OR   = 4'b0011;
  localparam logic [3:0] ALU_B_XOR  = 4'b0100;
  localparam logic [3:0] ALU_B_SLT  = 4'b0101;
  localparam logic [3:0] ALU_B_SLTU = 4'b0110;
  localparam logic [3:0] ALU_B_SLL  = 4'b0111;
  localparam logic [3:0] ALU_B_SRL  = 4'b1000;
  localparam logic [3:0] ALU_B_SRA  = 4'b1001;

  // Result multiplexer selects
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  localparam logic [1:0] RESULT_IMM = 2'b11;

  // Immediate format selects
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Control bundle carried from D into E
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic [2:0] branch_cond;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic       alu_a_pc;
    logic [3:0] alu_ctrl;
    logic       illegal;
  } ctrl_t;

  // ALU operation from funct3/funct7b5; sub only for R-type, shifts only when extended
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic f7b5,
                                         input logic is_r, input logic ext);
    logic [3:0] r;
    r = ALU_B_ADD;
    case (f3)
      3'b000:  r = (is_r && f7b5) ? ALU_B_SUB : ALU_B_ADD;
      3'b001:  r = ext ? ALU_B_SLL : ALU_B_ADD;
      3'b010:  r = ALU_B_SLT;
      3'b011:  r = ext ? ALU_B_SLTU : ALU_B_ADD;
      3'b100:  r = ext ? ALU_B_XOR : ALU_B_ADD;
      3'b101:  r = ext ? (f7b5 ? ALU_B_SRA : ALU_B_SRL) : ALU_B_ADD;
      3'b110:  r = ALU_B_OR;
      3'b111:  r = ALU_B_AND;
      default: r = ALU_B_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_dec.sv
// Combinational main + ALU decoder for the D stage.
module control_dec
  import control_pkg::*;
#(
  parameter int EXT_OPS = 0
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] imm_src,
  output ctrl_t      ctrl
);

  localparam logic EXT = (EXT_OPS != 0);

  // Decode opcode into control bundle; anything outside the enabled set is flagged illegal
  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    case (op)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RESULT_MEM;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = ALU_B_ADD;
      end
      OP_STORE: begin
        imm_src        = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_B_ADD;
      end
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_sel(funct3, funct7b5, 1'b1, EXT);
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = alu_sel(funct3, funct7b5, 1'b0, EXT);
      end
      OP_BR: begin
        imm_src          = IMM_B;
        ctrl.branch      = 1'b1;
        ctrl.branch_cond = funct3;
        ctrl.alu_ctrl    = ALU_B_SUB;
      end
      OP_JAL: begin
        imm_src         = IMM_J;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RESULT_PC4;
      end
      OP_JALR: begin
        if (EXT) begin
          ctrl.reg_write  = 1'b1;
          ctrl.jump       = 1'b1;
          ctrl.jalr       = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.result_src = RESULT_PC4;
          ctrl.alu_ctrl   = ALU_B_ADD;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EXT) begin
          imm_src         = IMM_U;
          ctrl.reg_write  = 1'b1;
          ctrl.result_src = RESULT_IMM;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (EXT) begin
          imm_src        = IMM_U;
          ctrl.reg_write = 1'b1;
          ctrl.alu_a_pc  = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_ctrl  = ALU_B_ADD;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Decode-stage control unit with registered E, M and W control stages.
module control_pipe
  import control_pkg::*;
#(
  parameter  int EXT_OPS = 0,
  localparam int ALUC_W  = (EXT_OPS != 0) ? 4 : 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              flush_m,
  output logic [2:0]        imm_src_d,
  output logic              illegal_d,
  output logic              valid_e,
  output logic              reg_write_e,
  output logic [1:0]        result_src_e,
  output logic              mem_write_e,
  output logic              branch_e,
  output logic [2:0]        branch_cond_e,
  output logic              jump_e,
  output logic              jalr_e,
  output logic              alu_src_e,
  output logic              alu_a_pc_e,
  output logic [ALUC_W-1:0] alu_ctrl_e,
  output logic              illegal_e,
  output logic              valid_m,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic [1:0]        result_src_m,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic [1:0]        result_src_w
);

  ctrl_t      w_ctrl_d;
  ctrl_t      r_ctrl_e;
  logic       r_valid_e;
  logic       r_valid_m;
  logic       r_reg_write_m;
  logic       r_mem_write_m;
  logic [1:0] r_result_src_m;
  logic       r_valid_w;
  logic       r_reg_write_w;
  logic [1:0] r_result_src_w;

  control_dec #(.EXT_OPS(EXT_OPS)) u_dec (
    .op       (op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .imm_src  (imm_src_d),
    .ctrl     (w_ctrl_d)
  );

  assign illegal_d = w_ctrl_d.illegal;

  // E stage: flush beats stall beats normal load from D
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= '0;
    end else if (flush_e) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= '0;
    end else if (stall_e) begin
      r_valid_e <= r_valid_e;
      r_ctrl_e  <= r_ctrl_e;
    end else begin
      r_valid_e <= 1'b1;
      r_ctrl_e  <= w_ctrl_d;
    end
  end

  // M stage: bubble on flush, on E stall, or when E holds an illegal opcode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_m      <= 1'b0;
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
    end else if (flush_m || stall_e || r_ctrl_e.illegal) begin
      r_valid_m      <= 1'b0;
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
    end else begin
      r_valid_m      <= r_valid_e;
      r_reg_write_m  <= r_ctrl_e.reg_write;
      r_mem_write_m  <= r_ctrl_e.mem_write;
      r_result_src_m <= r_ctrl_e.result_src;
    end
  end

  // W stage: unconditional copy of M
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_w      <= 1'b0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 2'b00;
    end else begin
      r_valid_w      <= r_valid_m;
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
    end
  end

  assign valid_e       = r_valid_e;
  assign reg_write_e   = r_ctrl_e.reg_write;
  assign result_src_e  = r_ctrl_e.result_src;
  assign mem_write_e   = r_ctrl_e.mem_write;
  assign branch_e      = r_ctrl_e.branch;
  assign branch_cond_e = r_ctrl_e.branch_cond;
  assign jump_e        = r_ctrl_e.jump;
  assign jalr_e        = r_ctrl_e.jalr;
  assign alu_src_e     = r_ctrl_e.alu_src;
  assign alu_a_pc_e    = r_ctrl_e.alu_a_pc;
  assign alu_ctrl_e    = r_ctrl_e.alu_ctrl[ALUC_W-1:0];
  assign illegal_e     = r_ctrl_e.illegal;

  assign valid_m       = r_valid_m;
  assign reg_write_m   = r_reg_write_m;
  assign mem_write_m   = r_mem_write_m;
  assign result_src_m  = r_result_src_m;

  assign valid_w       = r_valid_w;
  assign reg_write_w   = r_reg_write_w;
  assign result_src_w  = r_result_src_w;

  // The base set never produces the top ALU code bit
  if (ALUC_W < 4) begin : g_narrow_alu
    logic w_unused_alu;
    assign w_unused_alu = r_ctrl_e.alu_ctrl[3];
  end

endmodule
